// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring iteration, trial-subtracting the divisor from {rem, bit_in}.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_WIDTH
) (
  input  logic [W-1:0] rem,
  input  logic         bit_in,
  input  logic [W-1:0] dvsr,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);
  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         borrow;
  logic         unused_diff_msb;
  assign shifted = {rem, bit_in};
  assign {borrow, unused_diff_msb, diff} = {1'b0, shifted} - {2'b0, dvsr};
  assign rem_next = borrow ? shifted[W-1:0] : diff;
  assign q_bit = ~borrow;
endmodule

// File: rtl/divider_32bit_seq.sv
// divider_32bit_seq: 32-cycle restoring divider for DIVU/REMU; DIVIDER_SIGNED_EN adds DIV/REM.
module divider_32bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  div_state_e           state, state_n;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     rem_r, q_r, dvsr_r, a_mag, b_mag, rem_next, q_fin;
  logic                 neg_q, neg_r, q_bit, sgn, accept, b_zero;
`ifdef DIVIDER_SIGNED_EN
  assign sgn = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign sgn = 1'b0;
`endif
  assign accept = start && (state == IDLE || state == DONE);
  assign b_zero = divisor == '0;
  assign a_mag = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag = (sgn && divisor[WIDTH-1]) ? -divisor : divisor;
  assign busy = state == CALC;
  assign done = state == DONE;
  // q_r starts as the dividend magnitude and fills with quotient bits from the right
  div_step #(.W(WIDTH)) u_step (
    .rem     (rem_r),
    .bit_in  (q_r[WIDTH-1]),
    .dvsr    (dvsr_r),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );
  assign q_fin = {q_r[WIDTH-2:0], q_bit};
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = accept ? (b_zero ? DONE : CALC) : IDLE;
      CALC:       state_n = (cnt == '0) ? DONE : CALC;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      dvsr_r      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        rem_r  <= '0;
        q_r    <= a_mag;
        dvsr_r <= b_mag;
        cnt    <= DIV_CNT_W'(DIV_ITERS - 1);
        neg_q  <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r  <= sgn && dividend[WIDTH-1];
        if (b_zero) begin
          quotient    <= DIV_ZERO_QUOT;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == CALC) begin
        rem_r <= rem_next;
        q_r   <= q_fin;
        cnt   <= cnt - 1'b1;
        if (cnt == '0) begin
          quotient    <= neg_q ? -q_fin : q_fin;
          remainder   <= neg_r ? -rem_next : rem_next;
          div_by_zero <= 1'b0;
        end
      end
    end
  end
endmodule
